// File: rtl/draw_game_board_pkg.sv
// Shared constants and types for the Minesweeper board overlay stage.
package draw_game_board_pkg;

  localparam int unsigned SETTINGS_REG_NUM = 9;

  localparam int unsigned LEVEL         = 0;
  localparam int unsigned BOARD_XPOS    = 1;
  localparam int unsigned BOARD_YPOS    = 2;
  localparam int unsigned BOARD_SIZE    = 3;
  localparam int unsigned FIELD_SIZE    = 4;
  localparam int unsigned MINE_NUM      = 5;
  localparam int unsigned TIMER_SECONDS = 6;
  localparam int unsigned BORDER_WIDTH  = 7;
  localparam int unsigned RESERVED      = 8;

  localparam int unsigned SET_AW    = 8;
  localparam int unsigned SET_DW    = 16;
  localparam int unsigned BRD_AW    = 10;
  localparam int unsigned BRD_DW    = 8;
  localparam int unsigned FLD_IDX_W = 5;
  localparam int unsigned CTR_W     = 4;

  localparam int unsigned VGA_CW    = 11;
  localparam int unsigned VGA_RGB_W = 12;

  localparam int unsigned FLD_REVEALED = 0;
  localparam int unsigned FLD_FLAGGED  = 1;
  localparam int unsigned FLD_MINE     = 2;

  localparam logic [VGA_RGB_W-1:0] CLR_BORDER   = 12'h444;
  localparam logic [VGA_RGB_W-1:0] CLR_HIDDEN   = 12'hAAA;
  localparam logic [VGA_RGB_W-1:0] CLR_FLAGGED  = 12'hF00;
  localparam logic [VGA_RGB_W-1:0] CLR_REVEALED = 12'hDDD;
  localparam logic [VGA_RGB_W-1:0] CLR_MINE     = 12'h000;

  localparam logic [2:0] MAIN_MENU = 3'h0;
  localparam logic [2:0] MAIN_PLAY = 3'h2;

  typedef enum logic [1:0] {
    ST_IDLE          = 2'd0,
    ST_READ_SETTINGS = 2'd1,
    ST_DRAW          = 2'd2
  } state_t;

  typedef struct packed {
    logic [VGA_CW-1:0]    hcount;
    logic [VGA_CW-1:0]    vcount;
    logic                 hsync;
    logic                 vsync;
    logic                 hblnk;
    logic                 vblnk;
    logic [VGA_RGB_W-1:0] rgb;
  } vga_t;

  // Border wins; otherwise colour follows the revealed/flag/mine bits.
  function automatic logic [VGA_RGB_W-1:0] field_colour(input logic [BRD_DW-1:0] word,
                                                         input logic border);
    if (border)                   return CLR_BORDER;
    else if (!word[FLD_REVEALED]) return word[FLD_FLAGGED] ? CLR_FLAGGED : CLR_HIDDEN;
    else                          return word[FLD_MINE] ? CLR_MINE : CLR_REVEALED;
  endfunction

endpackage

// File: rtl/draw_game_board_if.sv
// VGA stream and read-only Wishbone bus interfaces.
interface vga_if;
  import draw_game_board_pkg::*;

  logic [VGA_CW-1:0]    hcount;
  logic [VGA_CW-1:0]    vcount;
  logic                 hsync;
  logic                 vsync;
  logic                 hblnk;
  logic                 vblnk;
  logic [VGA_RGB_W-1:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

interface wb_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
);
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          we;
  logic          stb;
  logic          cyc;
  logic          ack;

  modport master (output adr, dat_w, we, stb, cyc, input  dat_r, ack);
  modport slave  (input  adr, dat_w, we, stb, cyc, output dat_r, ack);
endinterface

// File: rtl/draw_game_board_wb_read_master.sv
// Single-read Wishbone sequencer: one outstanding read, stb/cyc held until ack.
module wb_read_master #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_adr,
  input  logic          i_ack,
  input  logic [DW-1:0] i_dat,
  output logic          o_stb,
  output logic          o_cyc,
  output logic [AW-1:0] o_adr,
  output logic          o_busy,
  output logic          o_ack_c,
  output logic [DW-1:0] o_dat_c
);

  logic          r_cyc;
  logic [AW-1:0] r_adr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cyc <= 1'b0;
      r_adr <= '0;
    end else if (r_cyc) begin
      if (i_ack) r_cyc <= 1'b0;
    end else if (i_req) begin
      r_cyc <= 1'b1;
      r_adr <= i_adr;
    end
  end

  assign o_stb   = r_cyc;
  assign o_cyc   = r_cyc;
  assign o_adr   = r_adr;
  assign o_busy  = r_cyc;
  assign o_ack_c = r_cyc & i_ack;
  assign o_dat_c = i_dat;

endmodule

// File: rtl/draw_game_board.sv
// Minesweeper board overlay: caches game settings, then paints fields over the VGA stream.
module draw_game_board
  import draw_game_board_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  main_state,
  wb_if.master        game_settings_wb,
  wb_if.master        game_board_wb,
  vga_if.in           in,
  vga_if.out          out
);

  state_t              r_state, w_state_next_c;
  logic [CTR_W-1:0]    r_settings_read_ctr;
  logic [SET_DW-1:0]   r_game_setup_cashe [SETTINGS_REG_NUM];

  logic                w_set_req_c, w_set_ack_c, w_set_busy, w_set_stb, w_set_cyc;
  logic [SET_AW-1:0]   w_set_adr;
  logic [SET_DW-1:0]   w_set_dat_c;
  logic                w_brd_req_c, w_brd_ack_c, w_brd_busy, w_brd_stb, w_brd_cyc;
  logic [BRD_AW-1:0]   w_brd_adr;
  logic [BRD_DW-1:0]   w_brd_dat_c;

  vga_t                r_s1, r_s2;
  logic [VGA_CW-1:0]   r_px, r_py;
  logic [FLD_IDX_W-1:0] r_col, r_row;
  logic                r_in_x, r_in_y;
  logic [BRD_DW-1:0]   r_cur_word, r_next_word;
  logic [BRD_AW-1:0]   r_next_adr;
  logic                r_next_has;

  assign w_set_req_c = (r_state == ST_READ_SETTINGS) && (main_state == MAIN_PLAY)
                       && (r_settings_read_ctr < CTR_W'(SETTINGS_REG_NUM));

  wb_read_master #(.AW(SET_AW), .DW(SET_DW)) u_settings_rd (
    .clk, .rst,
    .i_req(w_set_req_c), .i_adr(SET_AW'(r_settings_read_ctr)),
    .i_ack(game_settings_wb.ack), .i_dat(game_settings_wb.dat_r),
    .o_stb(w_set_stb), .o_cyc(w_set_cyc), .o_adr(w_set_adr), .o_busy(w_set_busy),
    .o_ack_c(w_set_ack_c), .o_dat_c(w_set_dat_c)
  );

  assign game_settings_wb.stb   = w_set_stb;
  assign game_settings_wb.cyc   = w_set_cyc;
  assign game_settings_wb.adr   = w_set_adr;
  assign game_settings_wb.we    = 1'b0;
  assign game_settings_wb.dat_w = '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next_c;
  end

  // An abort from READ_SETTINGS waits for the read in flight to complete.
  always_comb begin
    w_state_next_c = r_state;
    unique case (r_state)
      ST_IDLE:
        if (main_state == MAIN_PLAY) w_state_next_c = ST_READ_SETTINGS;
      ST_READ_SETTINGS:
        if (w_set_ack_c && (r_settings_read_ctr == CTR_W'(SETTINGS_REG_NUM - 1)))
          w_state_next_c = ST_DRAW;
        else if ((main_state != MAIN_PLAY) && (!w_set_busy || w_set_ack_c))
          w_state_next_c = ST_IDLE;
      ST_DRAW:
        if (main_state == MAIN_MENU) w_state_next_c = ST_IDLE;
      default: w_state_next_c = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_settings_read_ctr <= '0;
      for (int i = 0; i < int'(SETTINGS_REG_NUM); i++) r_game_setup_cashe[i] <= '0;
    end else begin
      if (w_state_next_c == ST_IDLE)
        r_settings_read_ctr <= '0;
      else if ((r_state == ST_READ_SETTINGS) && w_set_ack_c)
        r_settings_read_ctr <= r_settings_read_ctr + CTR_W'(1);
      if ((r_state == ST_READ_SETTINGS) && w_set_ack_c)
        r_game_setup_cashe[r_settings_read_ctr] <= w_set_dat_c;
    end
  end

  logic [VGA_CW-1:0]    w_xpos, w_ypos, w_fs, w_fs_m1, w_bw;
  logic [FLD_IDX_W-1:0] w_bs_m1;
  logic                 w_x_start_c, w_x_wrap_c, w_x_last_c, w_field_start_c;
  logic                 w_v_event_c, w_y_start_c;
  logic [BRD_AW-1:0]    w_target_c;
  logic                 w_next_hit_c, w_brd_ack_ok_c, w_border_c, w_in_board_c;

  assign w_xpos  = r_game_setup_cashe[BOARD_XPOS][VGA_CW-1:0];
  assign w_ypos  = r_game_setup_cashe[BOARD_YPOS][VGA_CW-1:0];
  assign w_fs    = r_game_setup_cashe[FIELD_SIZE][VGA_CW-1:0];
  assign w_bw    = r_game_setup_cashe[BORDER_WIDTH][VGA_CW-1:0];
  assign w_fs_m1 = w_fs - VGA_CW'(1);
  assign w_bs_m1 = FLD_IDX_W'(r_game_setup_cashe[BOARD_SIZE] - SET_DW'(1));

  assign w_x_start_c     = (in.hcount == w_xpos);
  assign w_x_wrap_c      = r_in_x && (r_px == w_fs_m1);
  assign w_x_last_c      = w_x_wrap_c && (r_col == w_bs_m1);
  assign w_field_start_c = w_x_start_c || (w_x_wrap_c && !w_x_last_c);
  assign w_v_event_c     = (in.vcount != r_s1.vcount);
  assign w_y_start_c     = w_v_event_c && (in.vcount == w_ypos);

  // Field position counters describe the pixel held in r_s1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_px <= '0; r_col <= '0; r_in_x <= 1'b0;
      r_py <= '0; r_row <= '0; r_in_y <= 1'b0;
    end else begin
      if (w_x_start_c) begin
        r_px <= '0; r_col <= '0; r_in_x <= 1'b1;
      end else if (w_x_wrap_c) begin
        r_px <= '0;
        if (w_x_last_c) r_in_x <= 1'b0;
        else            r_col  <= r_col + FLD_IDX_W'(1);
      end else if (r_in_x) begin
        r_px <= r_px + VGA_CW'(1);
      end
      if (w_y_start_c) begin
        r_py <= '0; r_row <= '0; r_in_y <= 1'b1;
      end else if (w_v_event_c && r_in_y) begin
        if (r_py == w_fs_m1) begin
          r_py <= '0;
          if (r_row == w_bs_m1) r_in_y <= 1'b0;
          else                  r_row  <= r_row + FLD_IDX_W'(1);
        end else begin
          r_py <= r_py + VGA_CW'(1);
        end
      end
    end
  end

  // Prefetch target is the field that starts next; stale acks are ignored by address.
  assign w_target_c     = {r_row, (r_in_x ? r_col + FLD_IDX_W'(1) : FLD_IDX_W'(0))};
  assign w_next_hit_c   = r_next_has && (r_next_adr == w_target_c);
  assign w_brd_req_c    = (r_state == ST_DRAW) && !w_next_hit_c;
  assign w_brd_ack_ok_c = w_brd_ack_c && (w_brd_adr == w_target_c);

  wb_read_master #(.AW(BRD_AW), .DW(BRD_DW)) u_board_rd (
    .clk, .rst,
    .i_req(w_brd_req_c), .i_adr(w_target_c),
    .i_ack(game_board_wb.ack), .i_dat(game_board_wb.dat_r),
    .o_stb(w_brd_stb), .o_cyc(w_brd_cyc), .o_adr(w_brd_adr), .o_busy(w_brd_busy),
    .o_ack_c(w_brd_ack_c), .o_dat_c(w_brd_dat_c)
  );

  assign game_board_wb.stb   = w_brd_stb;
  assign game_board_wb.cyc   = w_brd_cyc;
  assign game_board_wb.adr   = w_brd_adr;
  assign game_board_wb.we    = 1'b0;
  assign game_board_wb.dat_w = '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_word <= '0; r_next_word <= '0; r_next_adr <= '0; r_next_has <= 1'b0;
    end else begin
      if (r_state != ST_DRAW) begin
        r_next_has <= 1'b0;
      end else if (w_brd_ack_ok_c) begin
        r_next_has  <= 1'b1;
        r_next_adr  <= w_target_c;
        r_next_word <= w_brd_dat_c;
      end
      if (w_field_start_c) begin
        if (w_brd_ack_ok_c)    r_cur_word <= w_brd_dat_c;
        else if (w_next_hit_c) r_cur_word <= r_next_word;
      end
    end
  end

  assign w_border_c   = (({1'b0, r_px} + {1'b0, w_bw}) >= {1'b0, w_fs})
                     || (({1'b0, r_py} + {1'b0, w_bw}) >= {1'b0, w_fs});
  assign w_in_board_c = (r_state == ST_DRAW) && r_in_x && r_in_y && !r_s1.hblnk && !r_s1.vblnk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= {in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk, in.rgb};
      r_s2 <= r_s1;
      if (w_in_board_c) r_s2.rgb <= field_colour(r_cur_word, w_border_c);
    end
  end

  assign out.hcount = r_s2.hcount;
  assign out.vcount = r_s2.vcount;
  assign out.hsync  = r_s2.hsync;
  assign out.vsync  = r_s2.vsync;
  assign out.hblnk  = r_s2.hblnk;
  assign out.vblnk  = r_s2.vblnk;
  assign out.rgb    = r_s2.rgb;

endmodule

// File: tb/tb_draw_game_board.sv
// Directed bench for draw_game_board with Wishbone slave models and a video scoreboard.
module tb_draw_game_board;
  import draw_game_board_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] main_state = 3'h0;

  always #5 clk = ~clk;

  wb_if #(.AW(SET_AW), .DW(SET_DW)) sw();
  wb_if #(.AW(BRD_AW), .DW(BRD_DW)) bw();
  vga_if vin();
  vga_if vout();

  draw_game_board dut (
    .clk              (clk),
    .rst              (rst),
    .main_state       (main_state),
    .game_settings_wb (sw),
    .game_board_wb    (bw),
    .in               (vin),
    .out              (vout)
  );

  logic [15:0] set_mem [256];
  logic [7:0]  brd_mem [1024];
  int          stb_cnt = 0;
  int          total = 0;
  int          bad = 0;

  // One-cycle acking slaves.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw.ack <= 1'b0; sw.dat_r <= '0;
      bw.ack <= 1'b0; bw.dat_r <= '0;
    end else begin
      sw.ack <= sw.stb && sw.cyc && !sw.ack;
      if (sw.stb && sw.cyc && !sw.ack) sw.dat_r <= set_mem[sw.adr];
      bw.ack <= bw.stb && bw.cyc && !bw.ack;
      if (bw.stb && bw.cyc && !bw.ack) bw.dat_r <= brd_mem[bw.adr];
    end
  end

  always @(posedge clk) if (sw.stb || bw.stb) stb_cnt <= stb_cnt + 1;

  typedef struct {
    logic        chk;
    logic [11:0] rgb;
    logic        hs;
    logic [10:0] hc;
    logic [10:0] vc;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One pixel per clock: compare the pixel driven two cycles earlier, then drive a new one.
  task automatic step(input logic [10:0] h, input logic [10:0] v, input logic hs,
                      input logic hb, input logic [11:0] rgb, input logic c,
                      input logic [11:0] erg);
    exp_t e;
    @(posedge clk); #1;
    if (q.size() >= 2) begin
      e = q.pop_front();
      chk($sformatf("hsync h=%0d v=%0d", e.hc, e.vc), 32'(vout.hsync), 32'(e.hs));
      chk($sformatf("hcount v=%0d", e.vc), 32'(vout.hcount), 32'(e.hc));
      if (e.chk) chk($sformatf("rgb h=%0d v=%0d", e.hc, e.vc), 32'(vout.rgb), 32'(e.rgb));
    end
    vin.hcount = h; vin.vcount = v; vin.hsync = hs; vin.vsync = 1'b0;
    vin.hblnk = hb; vin.vblnk = 1'b0; vin.rgb = rgb;
    e.chk = c; e.rgb = erg; e.hs = hs; e.hc = h; e.vc = v;
    q.push_back(e);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(11'd0, 11'd0, 1'b0, 1'b0, 12'h123, 1'b0, 12'h0);
  endtask

  initial begin
    int          s0;
    logic [11:0] r;
    logic        found;

    for (int i = 0; i < 256; i++)  set_mem[i] = 16'(i);
    for (int i = 0; i < 1024; i++) brd_mem[i] = 8'h00;
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("rst_ctr", 32'(dut.r_settings_read_ctr), 32'd0);
    chk("rst_set_stb", 32'(sw.stb), 32'd0);
    chk("rst_brd_cyc", 32'(bw.cyc), 32'd0);
    chk("rst_out_rgb", 32'(vout.rgb), 32'd0);
    chk("rst_out_hcount", 32'(vout.hcount), 32'd0);
    rst = 1'b1;

    // IDLE hold: pass-through, no bus activity, single hsync pulse
    s0 = stb_cnt;
    for (int i = 0; i < 50; i++) begin
      r = 12'($urandom);
      step(11'(i), 11'd0, (i == 20), 1'b0, r, 1'b1, r);
      if (i == 22) chk("hsync_latency", 32'(vout.hsync), 32'd1);
    end
    chk("idle_no_stb", 32'(stb_cnt - s0), 32'd0);
    chk("set_we", 32'(sw.we), 32'd0);
    chk("brd_dat_w", 32'(bw.dat_w), 32'd0);

    // Settings load with word i = i
    main_state = MAIN_PLAY;
    step(11'd0, 11'd0, 1'b0, 1'b0, 12'h123, 1'b0, 12'h0);
    chk("state_read", 32'(dut.r_state), 32'(ST_READ_SETTINGS));
    idle_steps(100);
    chk("ctr_nonzero", 32'(dut.r_settings_read_ctr != 4'd0), 32'd1);
    chk("state_draw", 32'(dut.r_state), 32'(ST_DRAW));
    for (int i = 0; i < 9; i++)
      chk($sformatf("cache[%0d]", i), 32'(dut.r_game_setup_cashe[i]), 32'(i));

    // Return to IDLE
    main_state = MAIN_MENU;
    step(11'd0, 11'd0, 1'b0, 1'b0, 12'h123, 1'b0, 12'h0);
    chk("back_idle", 32'(dut.r_state), 32'(ST_IDLE));
    chk("back_idle_ctr", 32'(dut.r_settings_read_ctr), 32'd0);
    chk("cache_kept", 32'(dut.r_game_setup_cashe[5]), 32'd5);

    // Overlay: 8x8 board of 16-pixel fields at (100,100), 1-pixel border
    set_mem[0] = 16'd0;  set_mem[1] = 16'd100; set_mem[2] = 16'd100;
    set_mem[3] = 16'd8;  set_mem[4] = 16'd16;  set_mem[5] = 16'd0;
    set_mem[6] = 16'd0;  set_mem[7] = 16'd1;   set_mem[8] = 16'd0;
    brd_mem[0] = 8'h01;
    brd_mem[1] = 8'h02;
    main_state = MAIN_PLAY;
    idle_steps(60);
    chk("overlay_draw", 32'(dut.r_state), 32'(ST_DRAW));
    for (int v = 99; v <= 115; v++) begin
      for (int h = 0; h < 240; h++) begin
        logic [11:0] rr;
        logic [11:0] ex;
        logic        c;
        logic        hb;
        rr = 12'($urandom);
        ex = rr;
        c  = 1'b0;
        hb = (v == 105) && (h == 110);
        if (v == 105) begin
          case (h)
            99, 110, 228:   c = 1'b1;
            100, 105:       begin c = 1'b1; ex = CLR_REVEALED; end
            115, 131, 227:  begin c = 1'b1; ex = CLR_BORDER;   end
            116, 121:       begin c = 1'b1; ex = CLR_FLAGGED;  end
            132, 220:       begin c = 1'b1; ex = CLR_HIDDEN;   end
            default:        c = 1'b0;
          endcase
        end
        if (v == 100 && h == 100) begin c = 1'b1; ex = CLR_REVEALED; end
        if (v == 115 && h == 100) begin c = 1'b1; ex = CLR_BORDER;   end
        step(11'(h), 11'(v), 1'b0, hb, rr, c, ex);
      end
    end

    // Reset while a settings read is in flight
    main_state = MAIN_MENU;
    idle_steps(3);
    main_state = MAIN_PLAY;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      idle_steps(1);
      if (sw.stb) found = 1'b1;
    end
    chk("stb_before_rst", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_stb", 32'(sw.stb), 32'd0);
    chk("rst_mid_cyc", 32'(sw.cyc), 32'd0);
    chk("rst_mid_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("rst_mid_cache", 32'(dut.r_game_setup_cashe[1]), 32'd0);
    chk("rst_mid_ctr", 32'(dut.r_settings_read_ctr), 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    main_state = MAIN_MENU;
    idle_steps(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
